// File: rtl/uart_pkg.sv
// Register map, status/control bit positions and FSM encodings for the MMIO UART.
package uart_pkg;

  localparam logic [1:0] ADDR_RXDATA = 2'd0;
  localparam logic [1:0] ADDR_TXDATA = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_TX_BUSY     = 1;
  localparam int ST_TX_FULL     = 2;
  localparam int ST_OVERRUN     = 3;
  localparam int ST_FRAME_ERR   = 4;

  localparam int CTRL_CLR_OVR   = 0;
  localparam int CTRL_CLR_FERR  = 1;
  localparam int CTRL_FLUSH     = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Occupancy field in STATUS is 8 bits wide; deeper FIFOs pin at 255.
  function automatic logic [7:0] sat8(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO: push/pop in the same cycle both take effect, flush wins over both.
// Pop on empty is ignored; push on full is refused unless a pop frees a slot that cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_dat,
  input  logic          pop,
  input  logic          flush,
  output logic [7:0]    pop_dat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_port.sv
// 8N1 UART behind a 4-word MMIO window: RX FIFO, single TX holding register, sticky errors.
// Reads return one cycle after the strobe's rising edge; TX writes to a full holding register are dropped.
module uart_mmio_port
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ren,
  input  logic        wen,
  input  logic [1:0]  address,
  input  logic [31:0] data_in,
  input  logic [3:0]  byte_select,
  output logic [31:0] data_out,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        rx_irq
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF    = CW'(DIV / 2);
  localparam logic [CW-1:0] CNT_ONE = 1;

  logic        ren_q, wen_q;
  logic        rd_fire, wr_fire, ctrl_wr;
  logic        fifo_pop, fifo_full, fifo_empty, fifo_flush;
  logic [7:0]  fifo_dat;
  logic [AW:0] fifo_count;
  logic [31:0] status_w;
  logic        overrun, frame_err, overrun_set;

  logic [1:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic [7:0]    thr;
  logic          thr_vld;
  logic          tx_load;

  logic          rx_s1, rx_s2, rx_prev;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_push, frame_set;

  logic unused_bits;
  assign unused_bits = ^{data_in[31:8], byte_select[3:1]};

  assign rd_fire     = ren & ~ren_q;
  assign wr_fire     = wen & ~wen_q & byte_select[0];
  assign ctrl_wr     = wr_fire && (address == ADDR_CTRL);
  assign fifo_flush  = ctrl_wr & data_in[CTRL_FLUSH];
  assign fifo_pop    = rd_fire && (address == ADDR_RXDATA) && !fifo_empty;
  assign tx_load     = wr_fire && (address == ADDR_TXDATA) && !thr_vld;
  assign overrun_set = rx_push & fifo_full & ~fifo_pop;
  assign rx_irq      = ~fifo_empty;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rx_push),
    .push_dat (rx_shift),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    status_w                 = '0;
    status_w[15:8]           = sat8(32'(fifo_count));
    status_w[ST_FRAME_ERR]   = frame_err;
    status_w[ST_OVERRUN]     = overrun;
    status_w[ST_TX_FULL]     = thr_vld;
    status_w[ST_TX_BUSY]     = (tx_state != S_IDLE);
    status_w[ST_RX_NONEMPTY] = ~fifo_empty;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      data_out  <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ren_q <= ren;
      wen_q <= wen;
      if (rd_fire) begin
        case (address)
          ADDR_RXDATA: data_out <= fifo_empty ? 32'd0 : {23'd0, 1'b1, fifo_dat};
          ADDR_STATUS: data_out <= status_w;
          default:     data_out <= '0;
        endcase
      end
      // A flag raised in the same cycle as its clear survives.
      overrun   <= overrun_set | (overrun & ~(ctrl_wr & data_in[CTRL_CLR_OVR]));
      frame_err <= frame_set | (frame_err & ~(ctrl_wr & data_in[CTRL_CLR_FERR]));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      thr      <= '0;
      thr_vld  <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (thr_vld) begin
            tx_shift <= thr;
            thr_vld  <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= S_START;
            uart_tx  <= 1'b0;
          end
        end
        S_START: begin
          if (tx_cnt == DIV_M1) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= S_DATA;
            uart_tx  <= tx_shift[0];
          end else tx_cnt <= tx_cnt + CNT_ONE;
        end
        S_DATA: begin
          if (tx_cnt == DIV_M1) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= S_STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              uart_tx  <= tx_shift[1];
            end
          end else tx_cnt <= tx_cnt + CNT_ONE;
        end
        default: begin
          if (tx_cnt == DIV_M1) begin
            tx_cnt   <= '0;
            tx_state <= S_IDLE;
          end else tx_cnt <= tx_cnt + CNT_ONE;
        end
      endcase
      if (tx_load) begin
        thr     <= data_in[7:0];
        thr_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_state  <= S_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_push   <= 1'b0;
      frame_set <= 1'b0;
    end else begin
      rx_s1     <= uart_rx;
      rx_s2     <= rx_s1;
      rx_prev   <= rx_s2;
      rx_push   <= 1'b0;
      frame_set <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          // Mid-bit check rejects glitches shorter than half a bit.
          if (rx_cnt == HALF) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
          end else rx_cnt <= rx_cnt + CNT_ONE;
        end
        S_DATA: begin
          if (rx_cnt == DIV_M1) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else rx_bit <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt + CNT_ONE;
        end
        default: begin
          if (rx_cnt == DIV_M1) begin
            rx_cnt    <= '0;
            rx_state  <= S_IDLE;
            rx_push   <= rx_s2;
            frame_set <= ~rx_s2;
          end else rx_cnt <= rx_cnt + CNT_ONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio_port.sv
// Scoreboarded bench for uart_mmio_port: bus reads and TX frames are checked by independent monitors.
module tb_uart_mmio_port;

  localparam int BIT = 234;

  logic        clk = 1'b0;
  logic        reset;
  logic        ren, wen;
  logic [1:0]  address;
  logic [31:0] data_in;
  logic [3:0]  byte_select;
  logic [31:0] data_out;
  logic        uart_rx;
  logic        uart_tx;
  logic        rx_irq;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd_q[$];
  logic [7:0]  tx_q[$];
  logic        tx_mon_en   = 1'b0;
  logic        tx_in_frame = 1'b0;
  logic        m_ren_q     = 1'b0;
  logic        m_fire      = 1'b0;

  uart_mmio_port dut (
    .clk         (clk),
    .reset       (reset),
    .ren         (ren),
    .wen         (wen),
    .address     (address),
    .data_in     (data_in),
    .byte_select (byte_select),
    .data_out    (data_out),
    .uart_rx     (uart_rx),
    .uart_tx     (uart_tx),
    .rx_irq      (rx_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Read monitor: a rising ren edge seen at a clock means data_out is valid after that edge.
  always @(posedge clk) begin
    m_fire  <= ren & ~m_ren_q;
    m_ren_q <= ren;
  end

  always @(negedge clk) begin
    if (m_fire === 1'b1) begin
      if (rd_q.size() == 0) chk("unexpected_read", data_out, 32'hDEAD_BEEF);
      else chk("read", data_out, rd_q.pop_front());
    end
  end

  // TX monitor: each bit slot must hold its value on both its first and last cycle.
  initial begin
    logic [9:0] frame;
    logic       first;
    forever begin
      @(negedge clk);
      if (tx_mon_en && uart_tx === 1'b0) begin
        if (tx_q.size() == 0) begin
          chk("unexpected_tx_start", {31'd0, uart_tx}, 32'd1);
          for (int w = 0; w < 4 * BIT && uart_tx !== 1'b1; w++) @(negedge clk);
        end else begin
          tx_in_frame = 1'b1;
          frame = {1'b1, tx_q.pop_front(), 1'b0};
          first = 1'b0;
          for (int t = 0; t < 10 * BIT; t++) begin
            if (t > 0) @(negedge clk);
            if (t % BIT == 0) first = uart_tx;
            if (t % BIT == BIT - 1)
              chk($sformatf("tx_slot%0d", t / BIT), {30'd0, first, uart_tx},
                  {30'd0, frame[t / BIT], frame[t / BIT]});
          end
          tx_in_frame = 1'b0;
        end
      end
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got timeout want completion");
    total++;
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic rd(input logic [1:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    address = a;
    ren     = 1'b1;
    @(posedge clk); #1;
    ren = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address     = a;
    data_in     = d;
    byte_select = 4'h1;
    wen         = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (BIT) @(posedge clk);
    end
    uart_rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; ren = 1'b0; wen = 1'b0; address = 2'd0;
    data_in = '0; byte_select = 4'h0; uart_rx = 1'b1;

    // Reset and idle
    repeat (5) @(posedge clk); #1;
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_rx_irq", {31'd0, rx_irq}, 32'd0);
    reset = 1'b1;
    repeat (1000) @(posedge clk); #1;
    chk("idle_uart_tx", {31'd0, uart_tx}, 32'd1);
    chk("idle_rx_irq", {31'd0, rx_irq}, 32'd0);
    chk("idle_data_out", data_out, 32'd0);
    rd(2'd2, 32'h0000_0000);
    rd(2'd1, 32'h0000_0000);
    rd(2'd3, 32'h0000_0000);

    // TX: 0x55, then 0x3C into the holding register, then 0xFF dropped while full
    tx_mon_en = 1'b1;
    tx_q.push_back(8'h55);
    tx_q.push_back(8'h3C);
    wr(2'd1, 32'h55);
    wr(2'd1, 32'h3C);
    wr(2'd1, 32'hFF);
    rd(2'd2, 32'h0000_0006);
    for (int i = 0; i < 6000 && (tx_q.size() > 0 || tx_in_frame); i++) @(posedge clk);
    chk("tx_drained", {31'd0, (tx_q.size() > 0 || tx_in_frame)}, 32'd0);
    repeat (300) @(posedge clk); #1;
    rd(2'd2, 32'h0000_0000);

    // RX single byte
    send_byte(8'hA5, 1'b1);
    chk("rx_irq_set", {31'd0, rx_irq}, 32'd1);
    rd(2'd2, 32'h0000_0101);
    rd(2'd0, 32'h0000_01A5);
    chk("rx_irq_clr", {31'd0, rx_irq}, 32'd0);
    rd(2'd0, 32'h0000_0000);

    // Overflow: 17 bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
    rd(2'd2, 32'h0000_1009);
    for (int i = 0; i < 16; i++) rd(2'd0, 32'h100 + 32'(i));
    rd(2'd0, 32'h0000_0000);
    rd(2'd2, 32'h0000_0008);
    wr(2'd3, 32'h1);
    rd(2'd2, 32'h0000_0000);

    // Framing error, then a short glitch
    send_byte(8'h33, 1'b0);
    rd(2'd2, 32'h0000_0010);
    chk("ferr_no_push", {31'd0, rx_irq}, 32'd0);
    wr(2'd3, 32'h2);
    rd(2'd2, 32'h0000_0000);
    uart_rx = 1'b0;
    repeat (100) @(posedge clk);
    uart_rx = 1'b1;
    repeat (2500) @(posedge clk); #1;
    rd(2'd2, 32'h0000_0000);

    // Flush
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    rd(2'd2, 32'h0000_0201);
    wr(2'd3, 32'h4);
    rd(2'd2, 32'h0000_0000);

    // Held read strobe pops once
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    rd_q.push_back(32'h0000_0111);
    address = 2'd0;
    ren = 1'b1;
    repeat (20) @(posedge clk); #1;
    ren = 1'b0;
    repeat (2) @(posedge clk); #1;
    rd(2'd2, 32'h0000_0101);
    rd(2'd0, 32'h0000_0122);

    // Reset in the middle of a TX frame
    tx_mon_en = 1'b0;
    wr(2'd1, 32'h00);
    repeat (500) @(posedge clk); #2;
    chk("mid_tx_low", {31'd0, uart_tx}, 32'd0);
    reset = 1'b0;
    #1;
    chk("async_rst_tx", {31'd0, uart_tx}, 32'd1);
    chk("async_rst_dout", data_out, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    rd(2'd2, 32'h0000_0000);
    repeat (BIT * 11) @(posedge clk); #1;
    chk("post_rst_tx_idle", {31'd0, uart_tx}, 32'd1);

    repeat (5) @(posedge clk); #1;
    chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
